ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the keyboard over the same open-drain PS2_CLK/PS2_DATA pins that KeyboardDecoder listens on. It runs the full host request sequence (inhibit, request-to-send, 11-clock frame, device ACK) and returns a done/error pulse. It releases both lines whenever it is not transmitting, so device-to-host traffic is never disturbed.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 43 ++++
 rtl/ps2_host_tx.sv | 162 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host types, command codes and cycle-count helper
// Contents: state_t (host transmit FSM states), PS2_CMD_* / PS2_ACK byte codes,
//           cycle_count() to turn a time in ticks of some unit into clock cycles.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_ACK,
      ST_RELEASE
   } state_t;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_ACK         = 8'hFA;

   // Clock cycles spanned by n units, where one second holds ticks_per_sec units.
   function automatic int unsigned cycle_count(input int unsigned clk_hz,
                                               input int unsigned ticks_per_sec,
                                               input int unsigned n);
      return (clk_hz / ticks_per_sec) * n;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchronizer, glitch filter and falling-edge detect
// Ports: clk, rst_n (async active-low) | pin: raw open-drain line |
//        filt: filtered level (reset 1) | fall: one-cycle pulse when filt goes 1->0
module ps2_line_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic filt,
   output logic fall
);

   logic                meta;
   logic                sync;
   logic [FILT_LEN-2:0] hist;
   logic [FILT_LEN-1:0] window;

   // Current synchronized sample plus the FILT_LEN-1 before it.
   assign window = {hist, sync};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         sync <= 1'b1;
         hist <= '1;
         filt <= 1'b1;
         fall <= 1'b0;
      end else begin
         meta <= pin;
         sync <= meta;
         hist <= window[FILT_LEN-2:0];
         fall <= 1'b0;
         if (&window) begin
            filt <= 1'b1;
         end else if (~|window) begin
            filt <= 1'b0;
            fall <= filt;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Ports: clk, rst_n (async active-low) | PS2_CLK, PS2_DATA: open-drain, drive 0 or Z |
//        tx_data/tx_valid/tx_ready: byte request handshake (accepted only in IDLE) |
//        busy: transfer in progress | tx_done / tx_err: one-cycle completion pulses
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_MS = 15,
   parameter int FILT_LEN   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DATA,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int unsigned INHIBIT_CYC = cycle_count(CLK_HZ, 1_000_000, INHIBIT_US);
   localparam int unsigned TIMEOUT_CYC = cycle_count(CLK_HZ, 1_000, TIMEOUT_MS);
   localparam int unsigned MAX_CYC     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
   localparam int          CNT_W       = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(TIMEOUT_CYC);

   state_t           state, state_n;
   logic [9:0]       shift, shift_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             drv_clk, drv_clk_n;
   logic             drv_data, drv_data_n;
   logic             clk_filt, clk_fall;
   logic             data_meta, data_sync;

   assign PS2_CLK  = drv_clk  ? 1'b0 : 1'bz;
   assign PS2_DATA = drv_data ? 1'b0 : 1'bz;

   assign tx_ready = (state == ST_IDLE);
   assign busy     = ~tx_ready;

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .pin  (PS2_CLK),
      .filt (clk_filt),
      .fall (clk_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         data_meta <= PS2_DATA;
         data_sync <= data_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         shift    <= '0;
         bit_cnt  <= '0;
         cnt      <= '0;
         drv_clk  <= 1'b0;
         drv_data <= 1'b0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         bit_cnt  <= bit_cnt_n;
         cnt      <= cnt_n;
         drv_clk  <= drv_clk_n;
         drv_data <= drv_data_n;
      end
   end

   // tx_done/tx_err are decoded from the final cycle of a transfer, so the pulse
   // sits in the last busy cycle and tx_ready rises on the cycle after it.
   always_comb begin
      state_n    = state;
      shift_n    = shift;
      bit_cnt_n  = bit_cnt;
      cnt_n      = cnt;
      drv_clk_n  = drv_clk;
      drv_data_n = drv_data;
      tx_done    = 1'b0;
      tx_err     = 1'b0;
      case (state)
         ST_IDLE: begin
            drv_clk_n  = 1'b0;
            drv_data_n = 1'b0;
            if (tx_valid) begin
               shift_n   = {1'b1, ~^tx_data, tx_data};
               bit_cnt_n = '0;
               cnt_n     = '0;
               drv_clk_n = 1'b1;
               state_n   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
               cnt_n      = '0;
               drv_data_n = 1'b1;
               state_n    = ST_RTS;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_RTS: begin
            // Releasing PS2_CLK with PS2_DATA still low is the start bit.
            if (cnt == CNT_W'(1)) begin
               cnt_n     = '0;
               drv_clk_n = 1'b0;
               state_n   = ST_SEND;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_SEND, ST_ACK, ST_RELEASE: begin
            cnt_n = clk_fall ? '0 : cnt + 1'b1;
            if (cnt == TIMEOUT_LIM) begin
               tx_err     = 1'b1;
               drv_clk_n  = 1'b0;
               drv_data_n = 1'b0;
               state_n    = ST_IDLE;
            end else if (state == ST_SEND) begin
               if (clk_fall) begin
                  // A 1 bit (including the stop bit) is sent by releasing the line.
                  drv_data_n = ~shift[0];
                  shift_n    = {1'b0, shift[9:1]};
                  bit_cnt_n  = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd9) begin
                     state_n = ST_ACK;
                  end
               end
            end else if (state == ST_ACK) begin
               if (clk_fall) begin
                  if (data_sync) begin
                     tx_err  = 1'b1;
                     state_n = ST_IDLE;
                  end else begin
                     state_n = ST_RELEASE;
                  end
               end
            end else if (clk_filt && data_sync) begin
               tx_done = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, busy, tx_done, tx_err;
   wire        PS2_CLK, PS2_DATA;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int         n_total = 0;
   int         n_pass = 0;
   int         n_fail = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;
   logic       pulse_prev = 1'b0;
   logic       busy_in_pulse = 1'b0;
   logic       busy_after = 1'b1;
   logic       ready_after = 1'b0;
   logic       exp_q[$];

   pullup (PS2_CLK);
   pullup (PS2_DATA);
   assign PS2_CLK  = dev_clk_low  ? 1'b0 : 1'bz;
   assign PS2_DATA = dev_data_low ? 1'b0 : 1'bz;

   ps2_host_tx #(
      .CLK_HZ    (1_000_000),
      .INHIBIT_US(100),
      .TIMEOUT_MS(15),
      .FILT_LEN  (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .PS2_CLK (PS2_CLK),
      .PS2_DATA(PS2_DATA),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy    (busy),
      .tx_done (tx_done),
      .tx_err  (tx_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err)  err_cnt  <= err_cnt + 1;
      if (tx_done || tx_err) begin
         busy_in_pulse <= busy;
         pulse_prev    <= 1'b1;
      end else if (pulse_prev) begin
         busy_after  <= busy;
         ready_after <= tx_ready;
         pulse_prev  <= 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] d);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      exp_q.push_back(($countones(d) % 2 == 0) ? 1'b1 : 1'b0);
      exp_q.push_back(1'b1);
   endtask

   task automatic start(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic expect_inhibit(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_ready"}, tx_ready, 0);
      while (PS2_CLK === 1'b0 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_clk_low_cycles"}, n, 102);
      chk({tag, "_start_bit"}, PS2_DATA, 0);
   endtask

   task automatic device_frame(input string tag, input bit ack, input int nclk);
      logic got, want;
      repeat (20) @(negedge clk);
      for (int i = 1; i <= nclk; i++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         if (i <= 10) begin
            got = PS2_DATA;
            if (exp_q.size() == 0) begin
               chk($sformatf("%s_queue_bit%0d", tag, i), 1, 0);
            end else begin
               want = exp_q.pop_front();
               chk($sformatf("%s_bit%0d", tag, i), got, want);
            end
            if (i == 10 && ack) dev_data_low = 1'b1;
         end
         repeat (HALF) @(negedge clk);
      end
      dev_data_low = 1'b0;
   endtask

   task automatic wait_end(input int d0, input int e0);
      int n;
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      int d0, e0, k;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_err", tx_err, 0);
      chk("rst_clk_line", PS2_CLK, 1);
      chk("rst_data_line", PS2_DATA, 1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 0xED with ACK
      d0 = done_cnt; e0 = err_cnt;
      push_frame(PS2_CMD_SET_LED);
      start(PS2_CMD_SET_LED);
      expect_inhibit("ed");
      device_frame("ed", 1'b1, 11);
      wait_end(d0, e0);
      chk("ed_done_pulses", done_cnt - d0, 1);
      chk("ed_err_pulses", err_cnt - e0, 0);
      chk("ed_busy_during_pulse", busy_in_pulse, 1);
      chk("ed_busy_after_pulse", busy_after, 0);
      chk("ed_ready_after_pulse", ready_after, 1);

      // 0x07 then 0xFF with tx_valid held high throughout
      d0 = done_cnt; e0 = err_cnt;
      push_frame(8'h07);
      @(negedge clk);
      tx_data  = 8'h07;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_data = PS2_CMD_RESET;
      expect_inhibit("b2b1");
      device_frame("b2b1", 1'b1, 11);
      k = 0;
      while (tx_ready !== 1'b1 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_ready_back", tx_ready, 1);
      chk("b2b_first_done", done_cnt - d0, 1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      push_frame(PS2_CMD_RESET);
      expect_inhibit("b2b2");
      device_frame("b2b2", 1'b1, 11);
      wait_end(d0 + 1, e0);
      chk("b2b_done_pulses", done_cnt - d0, 2);
      chk("b2b_err_pulses", err_cnt - e0, 0);

      // Missing ACK
      d0 = done_cnt; e0 = err_cnt;
      push_frame(8'h5A);
      start(8'h5A);
      expect_inhibit("nak");
      device_frame("nak", 1'b0, 11);
      wait_end(d0, e0);
      chk("nak_err_pulses", err_cnt - e0, 1);
      chk("nak_done_pulses", done_cnt - d0, 0);
      chk("nak_clk_line", PS2_CLK, 1);
      chk("nak_data_line", PS2_DATA, 1);
      chk("nak_ready", tx_ready, 1);

      // Device never clocks
      d0 = done_cnt; e0 = err_cnt;
      push_frame(PS2_CMD_RESET);
      start(PS2_CMD_RESET);
      expect_inhibit("tmo");
      k = 0;
      while (tx_err !== 1'b1 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk("tmo_cycles", k, 15000);
      repeat (3) @(negedge clk);
      chk("tmo_clk_line", PS2_CLK, 1);
      chk("tmo_data_line", PS2_DATA, 1);
      chk("tmo_ready", tx_ready, 1);
      chk("tmo_err_pulses", err_cnt - e0, 1);
      chk("tmo_done_pulses", done_cnt - d0, 0);

      // Reset while the host drives data bit 4 (0) of 0xED
      d0 = done_cnt; e0 = err_cnt;
      push_frame(PS2_CMD_SET_LED);
      start(PS2_CMD_SET_LED);
      expect_inhibit("rst");
      device_frame("rst", 1'b0, 5);
      chk("rst_mid_data_low", PS2_DATA, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_clk_line", PS2_CLK, 1);
      chk("rst_mid_data_line", PS2_DATA, 1);
      chk("rst_mid_ready", tx_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      chk("rst_after_ready", tx_ready, 1);
      chk("rst_after_done", done_cnt - d0, 0);
      chk("rst_after_err", err_cnt - e0, 0);

      // tx_valid pulse of 0x55 while busy with 0xED
      d0 = done_cnt; e0 = err_cnt;
      push_frame(PS2_CMD_SET_LED);
      start(PS2_CMD_SET_LED);
      expect_inhibit("ign");
      @(negedge clk);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      device_frame("ign", 1'b1, 11);
      wait_end(d0, e0);
      chk("ign_done_pulses", done_cnt - d0, 1);
      chk("ign_err_pulses", err_cnt - e0, 0);
      repeat (100) @(negedge clk);
      chk("ign_no_second_frame", busy, 0);
      chk("ign_ready", tx_ready, 1);
      chk("ign_done_total", done_cnt - d0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
